// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM state type, prefix codes and letter make codes
// (the letter codes are also consumed by the downstream Morse encoder).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ENTER = 8'h5A;

  // Set-2 make codes for the letter keys
  localparam logic [7:0] PS2_KEY_A = 8'h1C;
  localparam logic [7:0] PS2_KEY_B = 8'h32;
  localparam logic [7:0] PS2_KEY_C = 8'h21;
  localparam logic [7:0] PS2_KEY_D = 8'h23;
  localparam logic [7:0] PS2_KEY_E = 8'h24;
  localparam logic [7:0] PS2_KEY_F = 8'h2B;
  localparam logic [7:0] PS2_KEY_G = 8'h34;
  localparam logic [7:0] PS2_KEY_H = 8'h33;
  localparam logic [7:0] PS2_KEY_I = 8'h43;
  localparam logic [7:0] PS2_KEY_J = 8'h3B;
  localparam logic [7:0] PS2_KEY_K = 8'h42;
  localparam logic [7:0] PS2_KEY_L = 8'h4B;
  localparam logic [7:0] PS2_KEY_M = 8'h3A;
  localparam logic [7:0] PS2_KEY_N = 8'h31;
  localparam logic [7:0] PS2_KEY_O = 8'h44;
  localparam logic [7:0] PS2_KEY_P = 8'h4D;
  localparam logic [7:0] PS2_KEY_Q = 8'h15;
  localparam logic [7:0] PS2_KEY_R = 8'h2D;
  localparam logic [7:0] PS2_KEY_S = 8'h1B;
  localparam logic [7:0] PS2_KEY_T = 8'h2C;
  localparam logic [7:0] PS2_KEY_U = 8'h3C;
  localparam logic [7:0] PS2_KEY_V = 8'h2A;
  localparam logic [7:0] PS2_KEY_W = 8'h1D;
  localparam logic [7:0] PS2_KEY_X = 8'h22;
  localparam logic [7:0] PS2_KEY_Y = 8'h35;
  localparam logic [7:0] PS2_KEY_Z = 8'h1A;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes raw PS/2 clock and data into clk, debounces the clock over FILTER_LEN
// samples and emits a one-cycle strobe on each accepted falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic clk_fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_f;
  logic [CW-1:0] cnt;

  // Idle bus is high, so every stage resets to 1 to avoid a false edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_f     <= 1'b1;
      cnt       <= '0;
      clk_fall  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_fall  <= 1'b0;
      if (clk_sync[1] == clk_f) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_sync[1];
        cnt      <= '0;
        clk_fall <= clk_f;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver: frames 11-bit packets, folds E0/F0 prefixes and
// reports make codes. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_valid,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          break_pending;
  logic          ext_pending;
  logic [TW-1:0] to_cnt;
  logic          data_s;
  logic          clk_fall;
  logic          frame_good;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  // Evaluated while the stop bit is being sampled
  always_comb begin
    frame_good = data_s;
`ifdef PS2_PARITY_CHECK_EN
    frame_good = data_s & odd_parity_ok(shift, par_bit);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      par_bit       <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      to_cnt        <= '0;
      code          <= 8'h00;
      code_ext      <= 1'b0;
      code_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state != IDLE && !clk_fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= (state == IDLE || clk_fall) ? '0 : to_cnt + 1'b1;
        if (clk_fall) begin
          case (state)
            IDLE: begin
              if (!data_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift   <= {data_s, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par_bit <= data_s;
              state   <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!frame_good) begin
                frame_err <= 1'b1;
              end else if (shift == PS2_BREAK) begin
                break_pending <= 1'b1;
              end else if (shift == PS2_EXT) begin
                ext_pending <= 1'b1;
              end else begin
                // Released keys are swallowed; only make codes reach the output
                if (!break_pending) begin
                  code       <= shift;
                  code_ext   <= ext_pending;
                  code_valid <= 1'b1;
                end
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed and randomized frame stimulus for ps2_scancode_rx against a byte-stream
// key model; set PS2_PARITY_CHECK_EN to match the RTL build.
module tb_ps2_scancode_rx;

  localparam int FL      = 4;
  localparam int TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_ext;
  logic       code_valid;
  logic       frame_err;
  logic [1:0] state_dbg;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_ext   (code_ext),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         tests = 0;
  int         fails = 0;
  int         err_cnt = 0;
  int         exp_err = 0;
  int         both_cnt = 0;
  int         valid_cyc = 0;
  int         stop_cyc = 0;
  bit         m_break = 1'b0;
  bit         m_ext = 1'b0;
  logic [8:0] last_exp = 9'h000;

  logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  always @(negedge clk) begin
    if (rst_n && code_valid) begin
      obs_q.push_back({code_ext, code});
      valid_cyc = cyc;
    end
    if (rst_n && frame_err) err_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: what the keyboard byte stream means
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) exp_err++;
    else if (b == 8'hF0) m_break = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_break) begin
        exp_q.push_back({m_ext, b});
        last_exp = {m_ext, b};
      end
      m_break = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit is_stop);
    ps2_data = b;
    wait_cycles(10);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    wait_cycles(20);
    ps2_clk = 1'b1;
    wait_cycles(10);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input logic stop_val);
    send_partial(b, 8);
    send_bit((~^b) ^ par_flip, 1'b0);
    send_bit(stop_val, 1'b1);
    ps2_data = 1'b1;
    wait_cycles(20);
  endtask

  task automatic send_and_model(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
    model_byte(b, 1'b1);
  endtask

  task automatic drain(input string tag);
    wait_cycles(40);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_code"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, err_cnt, exp_err);
    check({tag, "_hold"}, {code_ext, code}, last_exp);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    bit par_good;

    wait_cycles(5);
    check("reset_code", code, 8'h00);
    check("reset_ext", code_ext, 1'b0);
    check("reset_valid", code_valid, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // single make code with latency window check
    send_and_model(8'h1C);
    drain("make_1c");
    r = valid_cyc - stop_cyc;
    check("latency_window", (r >= FL + 2 && r <= FL + 5), 1'b1);

    // press, release: release suppressed
    send_and_model(8'h1C);
    send_and_model(8'hF0);
    send_and_model(8'h1C);
    drain("press_release");

    // extended key
    send_and_model(8'hE0);
    send_and_model(8'h5A);
    drain("ext_enter");

    // wrong parity
    send_frame(8'h24, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    par_good = 1'b0;
`else
    par_good = 1'b1;
`endif
    model_byte(8'h24, par_good);
    drain("bad_parity");

    // abandoned frame then a good one
    send_partial(8'h2D, 4);
    wait_cycles(TIMEOUT + 10);
    exp_err++;
    ps2_data = 1'b1;
    send_and_model(8'h2D);
    drain("timeout");

    // short low glitch on ps2_clk must be filtered
    ps2_data = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b0;
    wait_cycles(FL - 2);
    ps2_clk = 1'b1;
    wait_cycles(10);
    ps2_data = 1'b1;
    wait_cycles(10);
    send_and_model(8'h32);
    drain("glitch");

    // break pending, then reset during bit 5 of a frame
    send_and_model(8'hF0);
    send_partial(8'h2B, 5);
    ps2_data = 1'b1;
    wait_cycles(5);
    ps2_clk = 1'b0;
    wait_cycles(8);
    rst_n = 1'b0;
    m_break = 1'b0;
    m_ext = 1'b0;
    last_exp = 9'h000;
    wait_cycles(2);
    check("midreset_code", code, 8'h00);
    check("midreset_ext", code_ext, 1'b0);
    check("midreset_valid", code_valid, 1'b0);
    check("midreset_err", frame_err, 1'b0);
    check("midreset_state", state_dbg, 2'd0);
    ps2_clk = 1'b1;
    wait_cycles(10);
    rst_n = 1'b1;
    wait_cycles(10);
    send_and_model(8'h15);
    drain("after_reset");

    // randomized key stream with prefixes and broken stop bits
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      b = letters[$urandom_range(0, 25)];
      if (r == 0) send_and_model(8'hF0);
      else if (r == 1) send_and_model(8'hE0);
      else if (r == 2) begin
        send_frame(b, 1'b0, 1'b0);
        model_byte(b, 1'b0);
      end else send_and_model(b);
      drain("random");
    end

    check("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILTER_LEN, 8, number of consecutive identical synchronized samples required before ps2_clk is accepted as a new level.
REQ-002 Parameter TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge after which an in-progress frame is abandoned.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous to clk.
REQ-007 code  output  8  last accepted make code, held until the next one.
REQ-008 code_ext  output  1  code was preceded by the E0 prefix.
REQ-009 code_valid  output  1  one-cycle pulse: code/code_ext newly updated.
REQ-010 frame_err  output  1  one-cycle pulse: framing, parity or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; ps2_clk SHALL additionally be debounced by FILTER_LEN stable samples.
REQ-012 A bit SHALL be sampled from synchronized ps2_data on the clk cycle a filtered ps2_clk falling edge is detected.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-014 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE, no error.
REQ-015 DATA: shift 8 bits LSB first; after bit 7 -> PARITY.
REQ-016 PARITY: sample parity bit -> STOP.
REQ-017 STOP: sample stop bit -> IDLE; frame good only if stop = 1 and parity rule (REQ-027) passes; otherwise frame_err pulses next cycle and byte is discarded.
REQ-018 Timeout: in any state other than IDLE, TIMEOUT_CYCLES clk cycles with no falling edge -> IDLE, bit count cleared, frame_err pulse.
REQ-019 Good byte F0: set break_pending, no output.
REQ-020 Good byte E0: set ext_pending, no output.
REQ-021 Any other good byte with break_pending = 1: clear both pending flags, no output (key release suppressed).
REQ-022 Any other good byte with break_pending = 0: code <= byte, code_ext <= ext_pending, code_valid pulses, both pending flags cleared.
REQ-023 Latency: code_valid asserts exactly one clk cycle after the cycle the stop-bit falling edge is detected.
REQ-024 frame_err discards the byte but SHALL NOT clear break_pending or ext_pending.
REQ-025 code_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, bit count 0, shift register 0, pending flags 0, filter/synchronizer outputs 1 (bus idle), code 8'h00, code_ext 0, code_valid 0, frame_err 0; reset mid-frame discards the partial frame.

Configuration
REQ-027 Macro PS2_PARITY_CHECK_EN defined: frame good requires odd parity over 8 data bits plus parity bit; failure -> frame_err. Undefined: parity bit sampled and ignored; only the stop bit and timeout produce frame_err.

Structure
REQ-028 Package ps2_pkg SHALL hold the FSM state typedef, PS2_BREAK = 8'hF0, PS2_EXT = 8'hE0, PS2_ENTER = 8'h5A and the letter make-code constants shared with the downstream Morse encoder.
REQ-029 Sub-module ps2_sync_filter SHALL contain the synchronizers, the FILTER_LEN debounce and the falling-edge strobe; the FSM, timeout counter and prefix logic remain in ps2_scancode_rx.

Verification
REQ-030 Frame for 8'h1C ('a'), correct odd parity -> code = 8'h1C, code_ext = 0, single code_valid pulse one cycle after stop edge.
REQ-031 Sequence 1C, F0, 1C -> exactly one code_valid (8'h1C); release produces none.
REQ-032 Sequence E0, 5A -> code = 8'h5A, code_ext = 1, one code_valid.
REQ-033 Frame 8'h24 with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, no code_valid; without: code = 8'h24, code_valid.
REQ-034 Stop after 4 data bits for TIMEOUT_CYCLES+10 cycles, then full frame 8'h2D -> one frame_err, then code = 8'h2D, code_valid.
REQ-035 rst_n low during bit 5 of a frame, released, then frame 8'h15 -> outputs at reset values during reset, then code = 8'h15, code_valid, no frame_err.
